// File: rtl/k12a_reg_file_pkg.sv
// Shared types for the k12a register file: register select and exchange FSM states.
package k12a_reg_file_pkg;

    localparam int NUM_REGS = 4;

    typedef enum logic [1:0] {
        REG_SEL_A = 2'd0,
        REG_SEL_B = 2'd1,
        REG_SEL_C = 2'd2,
        REG_SEL_D = 2'd3
    } reg_sel_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        XCHG_SAVE    = 2'd1,
        XCHG_MOVE    = 2'd2,
        XCHG_RESTORE = 2'd3
    } xchg_state_t;

endpackage

// File: rtl/k12a_reg_file.sv
// k12a architectural register file: A..D, ALU operand taps, tri-state bus
// load/store, condition flag, and an atomic three-step XCHG A,<reg>.
module k12a_reg_file
    import k12a_reg_file_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset,
    input  reg_sel_t              reg_sel,
    input  logic                  reg_load,
    input  logic                  reg_store,
    input  logic                  xchg_start,
    input  logic                  cond_load,
    input  logic                  alu_condition,
    inout  wire [DATA_WIDTH-1:0]  data_bus,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  cond_flag,
    output logic                  busy
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [DATA_WIDTH-1:0]               r_temp;
    reg_sel_t                            r_sel_q;
    logic                                r_cond;
    xchg_state_t                         r_state;
    xchg_state_t                         w_state_nxt;

    logic w_idle;
    logic w_load_en;
    logic w_store_en;

    // Bus access only from IDLE, and a starting exchange wins over load/store.
    assign w_idle     = (r_state == IDLE);
    assign w_load_en  = reg_load  & w_idle & ~xchg_start;
    assign w_store_en = reg_store & w_idle & ~xchg_start;

    assign data_bus  = w_store_en ? r_regs[reg_sel] : {DATA_WIDTH{1'bz}};
    assign a         = r_regs[REG_SEL_A];
    assign b         = r_regs[REG_SEL_B];
    assign cond_flag = r_cond;
    assign busy      = ~w_idle;

    // Exchange FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Exchange FSM next state: a started exchange always runs all three steps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:         if (xchg_start) w_state_nxt = XCHG_SAVE;
            XCHG_SAVE:    w_state_nxt = XCHG_MOVE;
            XCHG_MOVE:    w_state_nxt = XCHG_RESTORE;
            XCHG_RESTORE: w_state_nxt = IDLE;
            default:      w_state_nxt = IDLE;
        endcase
    end

    // Register array, temp and exchange target; bus loads only when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_regs  <= {NUM_REGS{RESET_VALUE}};
            r_temp  <= '0;
            r_sel_q <= REG_SEL_A;
        end else begin
            case (r_state)
                IDLE: begin
                    if (xchg_start) r_sel_q <= reg_sel;
                    if (w_load_en)  r_regs[reg_sel] <= data_bus;
                end
                XCHG_SAVE:    r_temp <= r_regs[REG_SEL_A];
                XCHG_MOVE:    r_regs[REG_SEL_A] <= r_regs[r_sel_q];
                XCHG_RESTORE: r_regs[r_sel_q] <= r_temp;
                default: ;
            endcase
        end
    end

    // Condition flag follows the ALU only when asked, regardless of busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_cond <= 1'b0;
        else if (cond_load) r_cond <= alu_condition;
    end

endmodule

// File: tb/tb_k12a_reg_file.sv
// Directed bench for k12a_reg_file. The bus has weak pulldowns so a released
// bus reads 00, distinguishable from a driven non-zero register.
module tb_k12a_reg_file;
    import k12a_reg_file_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    reg_sel_t   reg_sel = REG_SEL_A;
    logic       reg_load = 1'b0;
    logic       reg_store = 1'b0;
    logic       xchg_start = 1'b0;
    logic       cond_load = 1'b0;
    logic       alu_condition = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] data_bus;
    logic [7:0] a, b;
    logic       cond_flag, busy;

    int n_vec = 0;
    int n_err = 0;

    assign data_bus = drv_en ? drv_val : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown pd (data_bus[i]);
    end

    k12a_reg_file #(.DATA_WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clock(clock), .reset(reset), .reg_sel(reg_sel), .reg_load(reg_load),
        .reg_store(reg_store), .xchg_start(xchg_start), .cond_load(cond_load),
        .alu_condition(alu_condition), .data_bus(data_bus), .a(a), .b(b),
        .cond_flag(cond_flag), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input reg_sel_t s, input logic [7:0] v);
        reg_sel = s; reg_load = 1'b1; drv_en = 1'b1; drv_val = v;
        tick();
        reg_load = 1'b0; drv_en = 1'b0;
    endtask

    initial begin
        // reset held, released away from an edge
        tick(); tick();
        reset = 1'b0;
        chk("rst_a", a, 8'h00);
        chk("rst_b", b, 8'h00);
        chk("rst_cond", {7'd0, cond_flag}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);

        // async reset pulse mid-cycle after some state exists
        load(REG_SEL_A, 8'h99);
        cond_load = 1'b1; alu_condition = 1'b1; tick(); cond_load = 1'b0; alu_condition = 1'b0;
        chk("pre_rst_a", a, 8'h99);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_a", a, 8'h00);
        chk("async_rst_cond", {7'd0, cond_flag}, 8'h00);
        reg_store = 1'b1; #1;
        chk("rst_bus_z", data_bus, 8'h00);
        reg_store = 1'b0;
        #1 reset = 1'b0;
        tick();

        // operand path
        load(REG_SEL_A, 8'h12);
        chk("op_a", a, 8'h12);
        load(REG_SEL_B, 8'h34);
        chk("op_b", b, 8'h34);
        chk("op_a_hold", a, 8'h12);

        // load then store C
        load(REG_SEL_C, 8'h5A);
        reg_sel = REG_SEL_C; reg_store = 1'b1; #1;
        chk("store_c", data_bus, 8'h5A);
        chk("store_a_unch", a, 8'h12);
        chk("store_b_unch", b, 8'h34);
        // load+store same cycle leaves C unchanged
        reg_load = 1'b1; tick(); reg_load = 1'b0; #1;
        chk("ldst_c", data_bus, 8'h5A);
        reg_store = 1'b0; #1;
        chk("no_store_z", data_bus, 8'h00);

        // exchange A=11, D=44 with sel=D
        load(REG_SEL_A, 8'h11);
        load(REG_SEL_D, 8'h44);
        reg_sel = REG_SEL_D; xchg_start = 1'b1; reg_store = 1'b1; #1;
        chk("xchg_pri_bus_z", data_bus, 8'h00);
        tick();
        reg_store = 1'b0;
        chk("x1_busy", {7'd0, busy}, 8'h01);
        // lockout during SAVE: load B=FF and a second start
        reg_sel = REG_SEL_B; reg_load = 1'b1; drv_en = 1'b1; drv_val = 8'hFF;
        xchg_start = 1'b1;
        tick();
        reg_load = 1'b0; drv_en = 1'b0; xchg_start = 1'b0;
        chk("x2_busy", {7'd0, busy}, 8'h01);
        chk("x2_a", a, 8'h11);
        reg_sel = REG_SEL_D; reg_store = 1'b1; #1;
        chk("busy_bus_z", data_bus, 8'h00);
        tick();
        reg_store = 1'b0;
        chk("x3_busy", {7'd0, busy}, 8'h01);
        chk("x3_a", a, 8'h44);
        tick();
        chk("x4_busy", {7'd0, busy}, 8'h00);
        chk("x4_a", a, 8'h44);
        chk("lock_b", b, 8'h34);
        reg_sel = REG_SEL_D; reg_store = 1'b1; #1;
        chk("x4_d", data_bus, 8'h11);
        reg_store = 1'b0;
        tick();
        chk("no_second_xchg", {7'd0, busy}, 8'h00);
        chk("no_second_a", a, 8'h44);

        // exchange with A itself
        reg_sel = REG_SEL_A; xchg_start = 1'b1; tick(); xchg_start = 1'b0;
        tick(); tick();
        chk("xa_busy3", {7'd0, busy}, 8'h01);
        tick();
        chk("xa_idle", {7'd0, busy}, 8'h00);
        chk("xa_a", a, 8'h44);

        // condition flag
        alu_condition = 1'b1; cond_load = 1'b1; tick(); cond_load = 1'b0;
        chk("cond_set", {7'd0, cond_flag}, 8'h01);
        alu_condition = 1'b0; tick();
        chk("cond_hold", {7'd0, cond_flag}, 8'h01);

        // cond_load honoured while busy, then reset mid-XCHG_MOVE
        reg_sel = REG_SEL_B; xchg_start = 1'b1; tick(); xchg_start = 1'b0;
        cond_load = 1'b1; alu_condition = 1'b0; tick(); cond_load = 1'b0;
        chk("cond_busy", {7'd0, cond_flag}, 8'h00);
        chk("move_busy", {7'd0, busy}, 8'h01);
        alu_condition = 1'b1; cond_load = 1'b1; tick(); cond_load = 1'b0;
        chk("cond_busy1", {7'd0, cond_flag}, 8'h01);
        // now in RESTORE? restart a clean exchange to hit MOVE exactly
        tick();
        chk("idle_again", {7'd0, busy}, 8'h00);
        chk("swap_a", a, 8'h34);
        chk("swap_b", b, 8'h44);
        reg_sel = REG_SEL_C; xchg_start = 1'b1; tick(); xchg_start = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_a", a, 8'h00);
        chk("mid_rst_b", b, 8'h00);
        chk("mid_rst_cond", {7'd0, cond_flag}, 8'h00);
        chk("mid_rst_busy", {7'd0, busy}, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", {7'd0, busy}, 8'h00);
        load(REG_SEL_A, 8'h77);
        chk("post_rst_load", a, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
